// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arb_pkg: FSM state encodings and width helper shared by the arbiter files.
// Contents: ST_IDLE/ST_BUSY/ST_GAP state constants, clog2() for parameter-derived widths.
package shared_reg_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: requester-side bus of the shared register arbiter.
// Signals: req/we/wdata driven by requesters; gnt/owner/busy/q/viol driven by the arbiter.
// Modports: master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int OW = clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  viol;

    modport master (output req, we, wdata, input gnt, owner, busy, q, viol);
    modport slave  (input req, we, wdata, output gnt, owner, busy, q, viol);
endinterface

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker; first requester after i_ptr (modulo NREQ) wins.
// Ports: i_req requests, i_ptr last owner, o_valid any request, o_winner chosen index.
module rr_picker
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int OW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [OW-1:0]   o_winner
);
    // Scan from farthest to nearest so the nearest requester after i_ptr is written last.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_valid  = 1'b1;
                o_winner = OW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin ownership arbiter for one shared WIDTH-bit register with hold-time preemption.
// Ports: clk, reset (async active-high), bus (slave modport: req/we/wdata in; gnt/owner/busy/q/viol out).
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input logic                 clk,
    input logic                 reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int OW = clog2(NREQ);
    localparam int HW = clog2(MAX_HOLD) + 1;

    logic [1:0]       r_state;
    logic [OW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold;
    logic [NREQ-1:0]  r_gnt;
    logic [OW-1:0]    r_owner;
    logic             r_busy;
    logic [WIDTH-1:0] r_q;
    logic             r_viol;

    logic             w_valid;
    logic [OW-1:0]    w_winner;
    logic             w_wr;
    logic             w_viol;
    logic             w_others;
    logic             w_rel;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    // r_gnt is zero outside BUSY, so these need no explicit state qualification.
    assign w_wr     = |(r_gnt & bus.req & bus.we);
    assign w_viol   = |(bus.we & ~(r_gnt & bus.req));
    assign w_others = |(bus.req & ~r_gnt);
    assign w_rel    = (r_state == ST_BUSY) &&
                      (!bus.req[r_owner] || (r_hold == HW'(MAX_HOLD - 1) && w_others));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= OW'(NREQ - 1);
            r_hold  <= '0;
            r_gnt   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
            r_viol  <= 1'b0;
        end else begin
            r_viol <= w_viol;
            if (w_wr) r_q <= bus.wdata[int'(r_owner)*WIDTH +: WIDTH];
            if (r_state == ST_IDLE) begin
                if (w_valid) begin
                    r_gnt   <= NREQ'(1) << w_winner;
                    r_owner <= w_winner;
                    r_busy  <= 1'b1;
                    r_hold  <= '0;
                    r_state <= ST_BUSY;
                end
            end else if (r_state == ST_BUSY) begin
                if (w_rel) begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_owner;
                    r_state <= ST_GAP;
                end else if (r_hold != HW'(MAX_HOLD - 1)) begin
                    r_hold <= r_hold + 1'b1;
                end
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.q     = r_q;
    assign bus.viol  = r_viol;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed and randomized checks of shared_reg_arbiter against an ownership-level model.
module tb_shared_reg_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model: who owns the register, how long they have held it, and whether we are in dead time.
    int         m_owner, m_ptr, m_hold;
    bit         m_busy, m_gap, m_viol;
    logic [7:0] m_q;

    shared_reg_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
    shared_reg_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_owner = 0; m_ptr = N - 1; m_hold = 0;
        m_busy = 0; m_gap = 0; m_viol = 0; m_q = 8'h00;
    endtask

    task automatic mdl_step();
        bit v, others;
        v = 0;
        others = 0;
        for (int j = 0; j < N; j++) begin
            if (bus.we[j] && !(m_busy && m_owner == j && bus.req[j])) v = 1;
            if (j != m_owner && bus.req[j]) others = 1;
        end
        if (m_busy && bus.req[m_owner] && bus.we[m_owner]) m_q = bus.wdata[m_owner*W +: W];
        if (m_busy) begin
            if (!bus.req[m_owner] || (m_hold == MH - 1 && others)) begin
                m_busy = 0; m_gap = 1; m_ptr = m_owner;
            end else if (m_hold < MH - 1) m_hold++;
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (bus.req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N; m_busy = 1; m_hold = 0;
                    break;
                end
            end
        end
        m_viol = v;
    endtask

    task automatic check_all();
        chk("gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("q", 32'(bus.q), 32'(m_q));
        chk("viol", 32'(bus.viol), 32'(m_viol));
        if (m_busy) chk("owner", 32'(bus.owner), 32'(m_owner));
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Called just after an edge; reset pulse lies entirely between edges.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        mdl_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_viol", 32'(bus.viol), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int order[$];
        int busy_ticks;
        logic [N-1:0] prev;
        bus.req = '0; bus.we = '0; bus.wdata = '0;
        do_reset();

        // 1: single owner, write, release
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        bus.we = 4'b0001; bus.wdata[7:0] = 8'hA5;
        tick();
        chk("t1_q", 32'(bus.q), 32'hA5);
        bus.we = '0; bus.req = '0;
        tick();
        chk("t1_rel", 32'(bus.gnt), 32'h0);
        chk("t1_viol", 32'(bus.viol), 32'h0);
        tick(); tick();

        // 2: all requesting, round-robin order and hold limit
        @(posedge clk); #1;
        do_reset();
        bus.req = 4'b1111;
        prev = '0;
        busy_ticks = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (t < 24 && bus.gnt != 0) busy_ticks++;
            if (prev == 0 && bus.gnt != 0)
                for (int i = 0; i < N; i++) if (bus.gnt[i]) order.push_back(i);
            prev = bus.gnt;
        end
        chk("t2_ngrants", 32'(order.size()), 32'd5);
        if (order.size() >= 5) begin
            chk("t2_g0", 32'(order[0]), 32'd0);
            chk("t2_g1", 32'(order[1]), 32'd1);
            chk("t2_g2", 32'(order[2]), 32'd2);
            chk("t2_g3", 32'(order[3]), 32'd3);
            chk("t2_g4", 32'(order[4]), 32'd0);
        end
        chk("t2_busyticks", 32'(busy_ticks), 32'd16);

        // 3: lone requester keeps grant, then yields at once to a newcomer
        do_reset();
        bus.req = 4'b0100;
        for (int t = 0; t < 20; t++) tick();
        chk("t3_hold", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0110;
        tick();
        chk("t3_preempt", 32'(bus.busy), 32'd0);
        tick();
        chk("t3_gap", 32'(bus.gnt), 32'h0);
        tick();
        chk("t3_handover", 32'(bus.gnt), 32'h2);

        // 4: foreign write rejected while owner write lands
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.we = 4'b1001; bus.wdata = {8'h3C, 8'h00, 8'h00, 8'h11};
        tick();
        chk("t4_q", 32'(bus.q), 32'h11);
        chk("t4_viol", 32'(bus.viol), 32'd1);
        bus.we = '0;
        tick();
        chk("t4_viol_end", 32'(bus.viol), 32'd0);

        // 5: owner drops req while writing
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.we = 4'b0100; bus.wdata[23:16] = 8'h55;
        tick();
        bus.req = '0; bus.wdata[23:16] = 8'h99;
        tick();
        chk("t5_q", 32'(bus.q), 32'h55);
        chk("t5_viol", 32'(bus.viol), 32'd1);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        bus.we = '0;
        tick(); tick();

        // 6: async reset mid-BUSY, then lowest active index wins
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.we = 4'b0010; bus.wdata[15:8] = 8'h77;
        tick();
        chk("t6_q", 32'(bus.q), 32'h77);
        bus.we = '0;
        do_reset();
        bus.req = 4'b1110;
        tick();
        chk("t6_first", 32'(bus.gnt), 32'h2);

        // Randomized traffic with sticky requests and sparse writes
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
            for (int i = 0; i < N; i++) bus.we[i] = ($urandom_range(0, 3) == 0);
            bus.wdata = 32'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
